// File: rtl/mole_game_if.sv
// Signal bundle between the mole game round controller and its surroundings:
// time base and switches in, LED drive, result pulses and BCD counters out.
interface mole_game_if #(
    parameter int LED_NUM      = 8,
    parameter int SCORE_DIGITS = 2
);
    logic                      start;
    logic                      tick;
    logic [LED_NUM-1:0]        sw;
    logic [LED_NUM-1:0]        led_state;
    logic                      hit;
    logic                      miss;
    logic [4*SCORE_DIGITS-1:0] score;
    logic [4*SCORE_DIGITS-1:0] misses;
    logic                      busy;
    logic                      game_over;

    modport master (
        output start, tick, sw,
        input  led_state, hit, miss, score, misses, busy, game_over
    );

    modport slave (
        input  start, tick, sw,
        output led_state, hit, miss, score, misses, busy, game_over
    );
endinterface

// File: rtl/mole_game_ctrl.sv
// Round controller for the LED/switch reaction game: lights a pseudo-random LED,
// judges the player's switch response against a tick timeout and keeps BCD tallies.
module mole_game_ctrl #(
    parameter int          LED_NUM       = 8,
    parameter int          TIMEOUT_TICKS = 4,
    parameter int          ROUNDS        = 16,
    parameter int          SCORE_DIGITS  = 2,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input logic         clk,
    input logic         clr,
    mole_game_if.slave  bus
);
    localparam int IDX_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam int CW    = 4 * SCORE_DIGITS;
    localparam logic [IDX_W:0]  LED_CNT    = (IDX_W + 1)'(LED_NUM);
    localparam logic [IDX_W:0]  LED_LAST   = (IDX_W + 1)'(LED_NUM - 1);
    localparam logic [IDX_W:0]  IDX_ONE    = (IDX_W + 1)'(1);
    localparam logic [3:0]      TO_LAST    = 4'(TIMEOUT_TICKS - 1);
    localparam logic [6:0]      ROUND_LAST = 7'(ROUNDS);
    localparam logic [CW-1:0]   ALL9       = {SCORE_DIGITS{4'h9}};

    typedef enum logic [2:0] {IDLE, ARM, WAIT, RESULT, OVER} state_t;

    state_t             state, next_state;
    logic [LED_NUM-1:0] sw_m, sw_s, sw_ref, diff, target_oh, led;
    logic [15:0]        lfsr;
    logic [IDX_W-1:0]   target;
    logic [3:0]         tcnt;
    logic [6:0]         round_cnt;
    logic [CW-1:0]      score, misses;
    logic               hit_q, miss_q;
    logic               dec_hit, dec_miss, clear_game, tick_count, busy, game_over;

    // Galois form of x^16+x^14+x^13+x^11+1; a non-zero state never decays to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [IDX_W-1:0] pick_target(input logic [IDX_W-1:0] low,
                                                     input logic [IDX_W-1:0] prev);
        logic [IDX_W:0] v;
        v = {1'b0, low};
        if (v >= LED_CNT) v = v - LED_CNT;
        if (v[IDX_W-1:0] == prev) v = (v == LED_LAST) ? '0 : v + IDX_ONE;
        return v[IDX_W-1:0];
    endfunction

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        if (v == ALL9) return v;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign diff      = sw_s ^ sw_ref;
    assign target_oh = LED_NUM'(1) << target;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        dec_hit    = 1'b0;
        dec_miss   = 1'b0;
        clear_game = 1'b0;
        tick_count = 1'b0;
        led        = '0;
        busy       = 1'b0;
        game_over  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    clear_game = 1'b1;
                    next_state = ARM;
                end
            end
            ARM: begin
                busy       = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                led  = target_oh;
                // Any switch movement outranks a coincident final tick.
                if (diff != '0) begin
                    next_state = RESULT;
                    if (diff == target_oh) dec_hit  = 1'b1;
                    else                   dec_miss = 1'b1;
                end else if (bus.tick) begin
                    tick_count = 1'b1;
                    if (tcnt == TO_LAST) begin
                        dec_miss   = 1'b1;
                        next_state = RESULT;
                    end
                end
            end
            RESULT: begin
                busy = 1'b1;
                if (bus.tick) next_state = (round_cnt == ROUND_LAST) ? OVER : ARM;
            end
            OVER: begin
                led       = '1;
                game_over = 1'b1;
                if (bus.start) begin
                    clear_game = 1'b1;
                    next_state = ARM;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sw_m      <= '0;
            sw_s      <= '0;
            sw_ref    <= '0;
            lfsr      <= LFSR_SEED;
            target    <= '0;
            tcnt      <= '0;
            round_cnt <= '0;
            score     <= '0;
            misses    <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            sw_m   <= bus.sw;
            sw_s   <= sw_m;
            lfsr   <= lfsr_next(lfsr);
            hit_q  <= dec_hit;
            miss_q <= dec_miss;
            if (clear_game) begin
                score     <= '0;
                misses    <= '0;
                round_cnt <= '0;
            end
            if (state == ARM) begin
                target <= pick_target(lfsr[IDX_W-1:0], target);
                sw_ref <= sw_s;
                tcnt   <= '0;
            end
            if (tick_count) tcnt <= tcnt + 4'd1;
            if (dec_hit)    score  <= bcd_inc(score);
            if (dec_miss)   misses <= bcd_inc(misses);
            if (dec_hit || dec_miss) round_cnt <= round_cnt + 7'd1;
        end
    end

    assign bus.led_state = led;
    assign bus.hit       = hit_q;
    assign bus.miss      = miss_q;
    assign bus.score     = score;
    assign bus.misses    = misses;
    assign bus.busy      = busy;
    assign bus.game_over = game_over;
endmodule

// File: doc/mole_game_ctrl.md
Name: mole_game_ctrl

Overview:
- Parametrised round controller for the LED/switch reaction game.
- Each round, it lights one pseudo-random LED out of LED_NUM and waits for the player to toggle the matching switch within a timeout. It scores the result in BCD and ends the game after ROUNDS rounds.
- Sits between the clock divider (which supplies the tick time base) and the seven-segment driver (which displays score and misses).

Parameters:
- LED_NUM, 8, number of LEDs and switches (2..16).
- TIMEOUT_TICKS, 4, ticks allowed per round before a miss (1..15).
- ROUNDS, 16, rounds per game (1..99).
- SCORE_DIGITS, 2, BCD digits per counter.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk, input, 1, system clock.
- clr, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse that starts a game.
- tick, input, 1, one-cycle time-base pulse from the divider.
- sw, input, LED_NUM, raw switch levels (asynchronous).
- led_state, output, LED_NUM, LED drive, active high.
- hit, output, 1, one-cycle pulse on a correct response.
- miss, output, 1, one-cycle pulse on a wrong response or timeout.
- score, output, 4*SCORE_DIGITS, hit count in BCD.
- misses, output, 4*SCORE_DIGITS, miss count in BCD.
- busy, output, 1, high while a game is running.
- game_over, output, 1, high after the last round until the next start.

Behaviour:
- Reset (clr low, asynchronous):
  - State goes to IDLE. All outputs are 0.
  - LFSR is loaded with LFSR_SEED. Round counter, timeout counter and target are 0.
  - Asserting reset mid-game aborts immediately; no hit or miss pulse is produced.
- Switch synchronisation: sw passes through a 2-FF synchroniser giving sw_s. All decisions use sw_s, so the first response can be seen 2 cycles after a switch edge.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances every cycle in every state and never reaches 0.
- Target selection:
  - Take the low ceil(log2(LED_NUM)) bits of the LFSR as v.
  - If v >= LED_NUM, use v - LED_NUM.
  - If the result equals the previous target, use (result+1) mod LED_NUM.
- State IDLE:
  - led_state=0, busy=0.
  - On start: clear score, misses and the round counter, then go to ARM.
- State ARM (1 cycle):
  - Pick the target and capture sw_ref <= sw_s.
  - Clear the timeout counter and go to WAIT.
  - busy=1 from this cycle until OVER.
- State WAIT:
  - led_state is one-hot at the target.
  - Define d = sw_s ^ sw_ref.
  - d equal to the one-hot target: hit, go to RESULT.
  - d non-zero and not equal to the one-hot target: miss, go to RESULT. This includes the target changing together with any other switch.
  - d = 0 and tick: increment the timeout counter. When it reaches TIMEOUT_TICKS, record a miss and go to RESULT.
  - A switch change and the final tick in the same cycle: the switch decision wins.
- State RESULT:
  - On the entry cycle only:
    - Pulse hit or miss for exactly 1 cycle.
    - Increment the corresponding BCD counter, with a carry per digit.
    - Saturate at all-9s; further increments hold the value.
    - Increment the round counter.
  - led_state=0 while in RESULT.
  - Remain until the next tick, which gives a blank gap.
  - On that tick: go to OVER if round counter == ROUNDS, otherwise go to ARM.
- State OVER:
  - led_state is all ones, game_over=1, busy=0.
  - score and misses hold their values.
  - On start: clear the counters and go to ARM; game_over drops in the same transition.
- start is ignored in ARM, WAIT and RESULT.
- tick is ignored in IDLE, ARM and OVER.
- Latency: a hit or miss pulse is asserted 1 cycle after the WAIT-state decision cycle. score and misses update in the same cycle as the pulse.
- Invariants:
  - hit and miss are never high together.
  - led_state is never multi-hot except in OVER.

Test Plan:
- Reset then start with sw static, ROUNDS=2, TIMEOUT_TICKS=4 -> each round misses after the 4th tick; misses=8'h02, score=0, game_over=1, led_state=8'hFF.
- Start, then toggle only the lit switch 1 cycle after it lights -> hit pulse 1 cycle wide, 3 cycles after the toggle, plus the ARM cycle; score=8'h01.
- Toggle a non-target switch, then the target and another switch in the same cycle in the next round -> two miss pulses, misses=8'h02, score unchanged.
- Toggle the target in the same cycle as the 4th tick -> hit, not miss.
- ROUNDS=99 with every round a hit, SCORE_DIGITS=2 -> score steps through 8'h09 to 8'h10 (BCD carry) and ends at 8'h99.
- Pull clr low during WAIT -> all outputs are 0 asynchronously and the state is IDLE; after release, one start produces a fresh game with the first target derived from LFSR_SEED.
